// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock-switch sequencer.
package clk_ctrl_pkg;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;
    localparam logic [SEL_W-1:0] SAFE_SRC = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SETTLE   = 2'd2,
        RETIRE   = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between the clock register block, the sequencer and the 4:1 clock mux.
interface clk_switch_ctrl_if;
    import clk_ctrl_pkg::*;

    logic               req_valid;
    logic [SEL_W-1:0]   req_sel;
    logic               req_ready;
    logic [NUM_SRC-1:0] src_rdy;
    logic [NUM_SRC-1:0] osc_en;
    logic [SEL_W-1:0]   mux_sel;
    logic [SEL_W-1:0]   cur_sel;
    logic               busy;
    logic               done;
    logic               err;
    logic               fault;

    modport master (
        output req_valid, req_sel, src_rdy,
        input  req_ready, osc_en, mux_sel, cur_sel, busy, done, err, fault
    );
    modport slave (
        input  req_valid, req_sel, src_rdy,
        output req_ready, osc_en, mux_sel, cur_sel, busy, done, err, fault
    );
endinterface

// File: rtl/clk_rdy_sync.sv
// Multi-flop synchronizer for one oscillator ready flag; q_pre is the value q takes on the next edge.
module clk_rdy_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_pre
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q     = ff[STAGES-1];
    assign q_pre = ff[STAGES-2];
endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences oscillator enable, mux select and old-source retirement for the glitch-free 4:1 clock mux.
// Registered outputs; requests are only taken in IDLE and never while a fallback is being triggered.
module clk_switch_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int RDY_TIMEOUT = 1024,
    parameter int SETTLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_switch_ctrl_if.slave ctl
);
    localparam int CNT_W = $clog2(max2(RDY_TIMEOUT, SETTLE_CYC) + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [SEL_W-1:0]   tgt_q, tgt_d, old_q, old_d;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d, cur_sel_q, cur_sel_d;
    logic [NUM_SRC-1:0] osc_en_q, osc_en_d;
    logic               fb_q, fb_d;
    logic               req_ready_q, req_ready_d, busy_q, busy_d;
    logic               done_q, done_d, err_q, err_d, fault_q, fault_d;
    logic [NUM_SRC-1:0] rdy_s, rdy_pre;
    logic               fb_trig, accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        clk_rdy_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (ctl.src_rdy[i]),
            .q     (rdy_s[i]),
            .q_pre (rdy_pre[i])
        );
    end

    assign fb_trig = (state_q == IDLE) && (cur_sel_q != SAFE_SRC) && !rdy_s[cur_sel_q];
    assign accept  = (state_q == IDLE) && !fb_trig && ctl.req_valid && req_ready_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_q       <= SAFE_SRC;
            old_q       <= SAFE_SRC;
            fb_q        <= 1'b0;
            mux_sel_q   <= SAFE_SRC;
            cur_sel_q   <= SAFE_SRC;
            osc_en_q    <= NUM_SRC'(1);
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            old_q       <= old_d;
            fb_q        <= fb_d;
            mux_sel_q   <= mux_sel_d;
            cur_sel_q   <= cur_sel_d;
            osc_en_q    <= osc_en_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fb_trig)                                 state_d = SETTLE;
                else if (accept && ctl.req_sel != cur_sel_q) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rdy_s[tgt_q])          state_d = SETTLE;
                else if (cnt_q == TO_LAST) state_d = IDLE;
            end
            SETTLE:  if (cnt_q == SET_LAST) state_d = RETIRE;
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_inc;
        tgt_d     = tgt_q;
        old_d     = old_q;
        fb_d      = fb_q;
        mux_sel_d = mux_sel_q;
        cur_sel_d = cur_sel_q;
        osc_en_d  = osc_en_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fb_trig) begin
                    mux_sel_d = SAFE_SRC;
                    old_d     = cur_sel_q;
                    fb_d      = 1'b1;
                    fault_d   = 1'b1;
                end else if (accept) begin
                    if (ctl.req_sel == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d                 = ctl.req_sel;
                        old_d                 = cur_sel_q;
                        fb_d                  = 1'b0;
                        osc_en_d[ctl.req_sel] = 1'b1;
                    end
                end
            end
            WAIT_RDY: begin
                if (rdy_s[tgt_q]) begin
                    mux_sel_d = tgt_q;
                    cnt_d     = '0;
                end else if (cnt_q == TO_LAST) begin
                    if (tgt_q != SAFE_SRC) osc_en_d[tgt_q] = 1'b0;
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    cnt_d  = '0;
                end
            end
            SETTLE: ;
            RETIRE: begin
                cnt_d     = '0;
                cur_sel_d = mux_sel_q;
                if (old_q != SAFE_SRC && old_q != mux_sel_q) osc_en_d[old_q] = 1'b0;
                done_d = !fb_q;
            end
            default: cnt_d = '0;
        endcase
        osc_en_d[SAFE_SRC] = 1'b1;
        busy_d = (state_d != IDLE);
        // Predict next cycle's fallback trigger so req_ready is already low in that cycle.
        req_ready_d = (state_d == IDLE) &&
                      !((cur_sel_d != SAFE_SRC) && !rdy_pre[cur_sel_d]);
    end

    assign ctl.req_ready = req_ready_q;
    assign ctl.osc_en    = osc_en_q;
    assign ctl.mux_sel   = mux_sel_q;
    assign ctl.cur_sel   = cur_sel_q;
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.err       = err_q;
    assign ctl.fault     = fault_q;
endmodule
